// File: rtl/mips_pkg.sv
// mips_pkg: shared LSU types (access size, FSM states) and the misalignment predicate.
package mips_pkg;
   typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} lsu_size_t;
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} lsu_state_t;
   // Size code 3 behaves as WORD.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      return (size == BYTE) ? 1'b0 : (size == HALF) ? off[0] : (off != 2'b00);
   endfunction
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: big-endian load extract/extend and store lane merge for one memory word.
module lsu_byte_lane import mips_pkg::*; (
   input  logic [0:3][7:0] word_i,
   input  logic [1:0]      off_i,
   input  logic [1:0]      size_i,
   input  logic            sign_i,
   input  logic [31:0]     wdata_i,
   output logic [31:0]     ldata_o,
   output logic [0:3][7:0] sdata_o
);
   logic [7:0]  b;
   logic [15:0] h;
   assign b = word_i[off_i];
   assign h = off_i[1] ? {word_i[2], word_i[3]} : {word_i[0], word_i[1]};
   assign ldata_o = (size_i == BYTE) ? {{24{sign_i & b[7]}}, b} :
                    (size_i == HALF) ? {{16{sign_i & h[15]}}, h} : word_i;
   always_comb begin
      sdata_o = word_i;
      if (size_i == BYTE) sdata_o[off_i] = wdata_i[7:0];
      else if (size_i == HALF) begin
         sdata_o[{off_i[1], 1'b0}] = wdata_i[15:8];
         sdata_o[{off_i[1], 1'b1}] = wdata_i[7:0];
      end else sdata_o = wdata_i;
   end
endmodule

// File: rtl/mips_lsu.sv
// mips_lsu: load/store unit with read-modify-write for sub-word stores.
// Define MIPS_LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of masking the address.
module mips_lsu import mips_pkg::*; #(
   parameter int MEM_LATENCY = 1,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [0:3][7:0]   mem_data_out,
   output logic [0:3][7:0]   mem_data_in,
   output logic              mem_write_en
);
   localparam int CW = $clog2(MEM_LATENCY + 1);
   lsu_state_t        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [1:0]        off_q, size_q;
   logic              sign_q, write_q, mwe_q, mwe_d, accept, word_st, trap;
   logic [31:0]       wdata_q, rdata_q, rdata_d, ldata;
   logic [ADDR_W-1:0] maddr_q;
   logic [0:3][7:0]   mdin_q, mdin_d, sdata;
   assign req_ready    = (state_q == IDLE) && !rst;
   assign accept       = req_valid && req_ready;
   assign word_st      = req_write && (req_size != BYTE) && (req_size != HALF);
   assign resp_valid   = state_q == RESP;
   assign busy         = state_q != IDLE;
   assign resp_rdata   = rdata_q;
   assign mem_addr     = maddr_q;
   assign mem_data_in  = mdin_q;
   assign mem_write_en = mwe_q;
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
   logic err_q;
   assign trap     = accept && misaligned(req_size, req_addr[1:0]);
   assign resp_err = err_q;
   always_ff @(posedge clk) err_q <= rst ? 1'b0 : trap;
`else
   assign trap     = 1'b0;
   assign resp_err = 1'b0;
`endif
   lsu_byte_lane u_lane (
      .word_i (mem_data_out),
      .off_i  (off_q),
      .size_i (size_q),
      .sign_i (sign_q),
      .wdata_i(wdata_q),
      .ldata_o(ldata),
      .sdata_o(sdata)
   );
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      mdin_d  = mdin_q;
      mwe_d   = 1'b0;
      case (state_q)
         IDLE:
            if (trap) begin
               state_d = RESP;
               rdata_d = '0;
            end else if (accept && word_st) begin
               state_d = WR;
               mwe_d   = 1'b1;
               mdin_d  = req_wdata;
            end else if (accept) begin
               state_d = RD_WAIT;
               cnt_d   = '0;
            end
         // Memory data is sampled on the last edge of the latency window.
         RD_WAIT:
            if (cnt_q == CW'(MEM_LATENCY - 1)) begin
               if (write_q) begin
                  state_d = WR;
                  mwe_d   = 1'b1;
                  mdin_d  = sdata;
               end else begin
                  state_d = RESP;
                  rdata_d = ldata;
               end
            end else cnt_d = cnt_q + CW'(1);
         WR: begin
            state_d = RESP;
            rdata_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         mdin_q  <= '0;
         mwe_q   <= 1'b0;
         maddr_q <= '0;
         off_q   <= '0;
         size_q  <= '0;
         sign_q  <= 1'b0;
         write_q <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         mdin_q  <= mdin_d;
         mwe_q   <= mwe_d;
         if (accept) begin
            maddr_q <= {req_addr[ADDR_W-1:2], 2'b00};
            off_q   <= req_addr[1:0];
            size_q  <= req_size;
            sign_q  <= req_signed;
            write_q <= req_write;
            wdata_q <= req_wdata;
         end
      end
   end
endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu: directed checks of mips_lsu with latency 1 (unit a) and latency 3 (unit b).
module tb_mips_lsu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;

   logic a_valid = 1'b0, a_write = 1'b0, a_signed = 1'b0;
   logic [1:0] a_size = 2'd0;
   logic [31:0] a_addr = '0, a_wdata = '0;
   logic a_ready, a_rv, a_err, a_busy, a_mwe;
   logic [31:0] a_rdata, a_maddr;
   logic [0:3][7:0] a_mdo, a_mdi;
   logic [31:0] mem_a [0:255];
   assign a_mdo = mem_a[a_maddr[9:2]];
   always @(posedge clk) if (a_mwe) mem_a[a_maddr[9:2]] <= a_mdi;

   mips_lsu #(.MEM_LATENCY(1), .ADDR_W(32)) dut_a (
      .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
      .req_size(a_size), .req_signed(a_signed), .req_addr(a_addr), .req_wdata(a_wdata),
      .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_err(a_err), .busy(a_busy),
      .mem_addr(a_maddr), .mem_data_out(a_mdo), .mem_data_in(a_mdi), .mem_write_en(a_mwe)
   );

   logic b_valid = 1'b0;
   logic [31:0] b_addr = '0;
   logic b_ready, b_rv, b_err, b_busy, b_mwe;
   logic [31:0] b_rdata, b_maddr, b_p1 = '0, b_p2 = '0;
   logic [0:3][7:0] b_mdo, b_mdi;
   always @(posedge clk) begin
      b_p1 <= b_maddr;
      b_p2 <= b_p1;
   end
   assign b_mdo = {8'hA0, b_p2[7:0], 8'h5C, 8'h3E};

   mips_lsu #(.MEM_LATENCY(3), .ADDR_W(32)) dut_b (
      .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_write(1'b0),
      .req_size(2'd2), .req_signed(1'b0), .req_addr(b_addr), .req_wdata(32'h0),
      .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_err(b_err), .busy(b_busy),
      .mem_addr(b_maddr), .mem_data_out(b_mdo), .mem_data_in(b_mdi), .mem_write_en(b_mwe)
   );

   int o_lat, o_wlat, o_wcnt;
   logic [31:0] o_wdat, o_rd, o_ma;
   logic o_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request on unit a; lat counts cycles from the accept edge (1 = first cycle after it).
   task automatic a_op(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
      @(negedge clk);
      a_valid = 1'b1; a_write = wr; a_size = sz; a_signed = sg; a_addr = ad; a_wdata = wd;
      @(negedge clk);
      a_valid = 1'b0;
      o_lat = 1; o_wlat = 0; o_wcnt = 0; o_wdat = '0; o_ma = a_maddr;
      forever begin
         if (a_mwe) begin
            o_wcnt++;
            o_wlat = o_lat;
            o_wdat = a_mdi;
         end
         if (a_rv || o_lat >= 20) break;
         @(negedge clk);
         o_lat++;
      end
      o_rd = a_rdata;
      o_err = a_err;
   endtask

   logic [31:0] b_seq [3];
   int acc [3];
   int k, r, n, idle;
   logic fire;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", a_busy, 1'b0);
      chk("rst_resp_valid", a_rv, 1'b0);
      chk("rst_write_en", a_mwe, 1'b0);
      chk("rst_mem_addr", a_maddr, 32'h0);
      chk("rst_mem_data_in", a_mdi, 32'h0);
      chk("rst_rdata", a_rdata, 32'h0);
      chk("rst_err", a_err, 1'b0);
      chk("rst_ready_low", a_ready, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready_high", a_ready, 1'b1);

      // Reset while the load waits for memory.
      a_valid = 1'b1; a_write = 1'b0; a_size = 2'd0; a_signed = 1'b1; a_addr = 32'h100;
      @(negedge clk);
      a_valid = 1'b0;
      chk("t1_busy_rd_wait", a_busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("t1_no_resp", a_rv, 1'b0);
      chk("t1_idle", a_busy, 1'b0);
      chk("t1_no_write", a_mwe, 1'b0);
      chk("t1_ready_in_rst", a_ready, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("t1_ready_after", a_ready, 1'b1);
      chk("t1_no_resp_after", a_rv, 1'b0);

      a_op(1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF1234);
      chk("init_sw_data", o_wdat, 32'h80FF1234);
      a_op(1'b0, 2'd0, 1'b1, 32'h100, 32'h0);
      chk("lb_s100", o_rd, 32'hFFFFFF80);
      chk("lb_s100_lat", o_lat, 2);
      a_op(1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
      chk("lbu_101", o_rd, 32'h000000FF);
      chk("lbu_101_lat", o_lat, 2);
      a_op(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
      chk("lh_102", o_rd, 32'h00001234);
      chk("lh_102_lat", o_lat, 2);
      a_op(1'b0, 2'd1, 1'b1, 32'h100, 32'h0);
      chk("lh_s100", o_rd, 32'hFFFF80FF);
      a_op(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
      chk("size3_word", o_rd, 32'h80FF1234);

      a_op(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF);
      chk("sw_wlat", o_wlat, 1);
      chk("sw_wcnt", o_wcnt, 1);
      chk("sw_lanes", o_wdat, 32'hDEADBEEF);
      chk("sw_lat", o_lat, 2);
      chk("sw_rdata0", o_rd, 32'h0);
      chk("sw_mem", mem_a[8'h80], 32'hDEADBEEF);

      a_op(1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344);
      a_op(1'b1, 2'd0, 1'b0, 32'h203, 32'h555555AA);
      chk("sb_word", o_wdat, 32'h112233AA);
      chk("sb_wlat", o_wlat, 2);
      chk("sb_wcnt", o_wcnt, 1);
      chk("sb_lat", o_lat, 3);
      a_op(1'b1, 2'd1, 1'b0, 32'h200, 32'h0000BEEF);
      chk("sh_word", o_wdat, 32'hBEEF33AA);
      chk("sh_lat", o_lat, 3);
      a_op(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
      chk("lw_200", o_rd, 32'hBEEF33AA);

      a_op(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
      chk("mis_err", o_err, 1'b1);
      chk("mis_lat", o_lat, 1);
      chk("mis_rdata", o_rd, 32'h0);
      chk("mis_no_write", o_wcnt, 0);
`else
      chk("mis_err", o_err, 1'b0);
      chk("mis_lat", o_lat, 2);
      chk("mis_rdata", o_rd, 32'h80FF1234);
      chk("mis_addr", o_ma, 32'h100);
`endif

      // Back-to-back loads on the latency-3 unit with req_valid held.
      b_seq = '{32'h10, 32'h24, 32'h38};
      @(negedge clk);
      b_valid = 1'b1; b_addr = b_seq[0];
      k = 0; r = 0; n = 0; idle = 0;
      while (r < 3 && n < 100) begin
         fire = b_valid && b_ready;
         @(negedge clk);
         n++;
         if (fire) begin
            acc[k] = n;
            k++;
            if (k < 3) b_addr = b_seq[k];
            else b_valid = 1'b0;
         end
         if (b_rv) begin
            chk("b2b_lat", n - acc[r] + 1, 4);
            chk("b2b_data", b_rdata, {8'hA0, b_seq[r][7:0], 16'h5C3E});
            chk("b2b_err", b_err, 1'b0);
            r++;
         end else if (!b_busy && k > 0) idle++;
      end
      chk("b2b_count", r, 3);
      chk("b2b_idle_gaps", idle, 2);
      chk("b2b_no_write", b_mwe, 1'b0);
      chk("b2b_mdi", b_mdi, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
